nx_dly_reg_master: RTL and testbench

Fabric-side initiator for the delay-register access port on the NX_SER/NX_DES/NX_SERDES I/O cells, i.e. the DCK/DRL/DS/DRA/DRI/DRO/DID group. It accepts read and write commands on a valid/ready interface and sequences DS/DRA/DRI/DRL around a single DCK pulse. For reads it waits a fixed latency, samples DRO and DID, and returns a response. It sits between the I/O calibration logic and one I/O cell instance.

---
 rtl/nx_dly_pkg.sv | 34 +++
 rtl/nx_dly_reg_master.sv | 165 ++++++++++++++++
 tb/tb_nx_dly_reg_master.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nx_dly_pkg.sv
// Shared types and constants for the NX I/O cell delay-register port initiator.
// Contents:
//   dly_state_t : sequencer states
//   dly_cmd_t   : one latched register-port command {wr, sel, addr, wdata}
//   cyc_to_cnt  : converts a cycle count (1..15) into a down-counter load value
package nx_dly_pkg;

    localparam int DLY_ADDR_W = 6;
    localparam int DLY_DATA_W = 6;
    localparam int DLY_SEL_W  = 2;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        WAIT,
        RESP
    } dly_state_t;

    typedef struct packed {
        logic                  wr;
        logic [DLY_SEL_W-1:0]  sel;
        logic [DLY_ADDR_W-1:0] addr;
        logic [DLY_DATA_W-1:0] wdata;
    } dly_cmd_t;

    // A phase lasting n cycles is counted n-1 down to 0; n is at most 15,
    // so the 4-bit counter never wraps.
    function automatic logic [3:0] cyc_to_cnt(input int unsigned n);
        return 4'(n - 1);
    endfunction

endpackage

// File: rtl/nx_dly_reg_master.sv
// Fabric-side initiator for the NX_SER/NX_DES/NX_SERDES delay-register port
// (DCK/DRL/DS/DRA/DRI/DRO/DID).
// Accepts one read or write command at a time, drives DS/DRA/DRI/DRL around a
// single DCK pulse, and for reads samples DRO/DID a fixed latency after DCK
// falls before returning a response.
// Ports:
//   CK, RN                      clock, asynchronous active-low reset
//   REQ_VALID/REQ_READY         command handshake
//   REQ_WR/SEL/ADDR/WDATA       command fields (1 = write)
//   RSP_VALID/RSP_READY         response handshake, RSP_VALID held until taken
//   RSP_WR/RSP_RDATA/RSP_ID     response fields (data/id are 0 for writes)
//   DCK/DRL/DS/DRA/DRI          registered outputs to the I/O cell
//   DRO/DID                     read data and delay ID from the I/O cell
module nx_dly_reg_master
    import nx_dly_pkg::*;
#(
    parameter int SETUP_CYC = 1,
    parameter int HOLD_CYC  = 1,
    parameter int READ_LAT  = 2
) (
    input  logic                  CK,
    input  logic                  RN,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WR,
    input  logic [DLY_SEL_W-1:0]  REQ_SEL,
    input  logic [DLY_ADDR_W-1:0] REQ_ADDR,
    input  logic [DLY_DATA_W-1:0] REQ_WDATA,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic                  RSP_WR,
    output logic [DLY_DATA_W-1:0] RSP_RDATA,
    output logic [DLY_DATA_W-1:0] RSP_ID,
    output logic                  DCK,
    output logic                  DRL,
    output logic [DLY_SEL_W-1:0]  DS,
    output logic [DLY_ADDR_W-1:0] DRA,
    output logic [DLY_DATA_W-1:0] DRI,
    input  logic [DLY_DATA_W-1:0] DRO,
    input  logic [DLY_DATA_W-1:0] DID
);

    if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_bad_setup
        $error("nx_dly_reg_master: SETUP_CYC must be in 1..15");
    end
    if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold
        $error("nx_dly_reg_master: HOLD_CYC must be in 1..15");
    end
    if (READ_LAT < 1 || READ_LAT > 15) begin : g_bad_lat
        $error("nx_dly_reg_master: READ_LAT must be in 1..15");
    end

    dly_state_t            state;
    logic [3:0]            cnt;
    dly_cmd_t              cmd_q;
    logic [DLY_DATA_W-1:0] rdata_q;
    logic [DLY_DATA_W-1:0] id_q;

    // Port outputs are registered from the state held before each edge, so
    // DS/DRA/DRI/DRL appear one cycle after accept, DCK is high in the cycle
    // after STROBE, and RSP_VALID rises in the cycle after RESP is entered.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state     <= IDLE;
            cnt       <= '0;
            cmd_q     <= '0;
            rdata_q   <= '0;
            id_q      <= '0;
            REQ_READY <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_WR    <= 1'b0;
            RSP_RDATA <= '0;
            RSP_ID    <= '0;
            DCK       <= 1'b0;
            DRL       <= 1'b0;
            DS        <= '0;
            DRA       <= '0;
            DRI       <= '0;
        end else begin
            DCK <= (state == STROBE);

            case (state)
                IDLE: begin
                    REQ_READY <= 1'b1;
                    if (REQ_VALID && REQ_READY) begin
                        cmd_q     <= '{wr: REQ_WR, sel: REQ_SEL,
                                       addr: REQ_ADDR, wdata: REQ_WDATA};
                        rdata_q   <= '0;
                        id_q      <= '0;
                        cnt       <= cyc_to_cnt(SETUP_CYC);
                        REQ_READY <= 1'b0;
                        state     <= SETUP;
                    end
                end

                SETUP: begin
                    DRL <= cmd_q.wr;
                    DS  <= cmd_q.sel;
                    DRA <= cmd_q.addr;
                    DRI <= cmd_q.wdata;
                    if (cnt == 4'd0) begin
                        state <= STROBE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                STROBE: begin
                    cnt   <= cyc_to_cnt(HOLD_CYC);
                    state <= HOLD;
                end

                HOLD: begin
                    if (cnt == 4'd0) begin
                        if (cmd_q.wr) begin
                            state <= RESP;
                        end else begin
                            cnt   <= cyc_to_cnt(READ_LAT);
                            state <= WAIT;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                WAIT: begin
                    if (cnt == 4'd0) begin
                        rdata_q <= DRO;
                        id_q    <= DID;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                RESP: begin
                    if (!RSP_VALID) begin
                        RSP_VALID <= 1'b1;
                        RSP_WR    <= cmd_q.wr;
                        RSP_RDATA <= rdata_q;
                        RSP_ID    <= id_q;
                    end else if (RSP_READY) begin
                        // Response taken: release the I/O cell bus and reopen
                        // the command port on the same edge RSP_VALID drops.
                        RSP_VALID <= 1'b0;
                        RSP_WR    <= 1'b0;
                        RSP_RDATA <= '0;
                        RSP_ID    <= '0;
                        DRL       <= 1'b0;
                        DS        <= '0;
                        DRA       <= '0;
                        DRI       <= '0;
                        REQ_READY <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nx_dly_reg_master.sv
module tb_nx_dly_reg_master;

  int checks;
  int failures;

  task automatic fail(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    failures++;
    $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  logic CK = 1'b0;
  always #5 CK = ~CK;
  logic RN;

  logic       req_valid, req_ready, req_wr;
  logic [1:0] req_sel;
  logic [5:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_ready, rsp_wr;
  logic [5:0] rsp_rdata, rsp_id;
  logic       dck, drl;
  logic [1:0] ds;
  logic [5:0] dra, dri, dro, did;

  assign dro = dra ^ 6'h34;
  assign did = 6'h11;

  nx_dly_reg_master dut (
    .CK(CK), .RN(RN),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WR(req_wr),
    .REQ_SEL(req_sel), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_WR(rsp_wr),
    .RSP_RDATA(rsp_rdata), .RSP_ID(rsp_id),
    .DCK(dck), .DRL(drl), .DS(ds), .DRA(dra), .DRI(dri),
    .DRO(dro), .DID(did)
  );

  logic       p_req_valid, p_req_ready, p_req_wr;
  logic [1:0] p_req_sel;
  logic [5:0] p_req_addr, p_req_wdata;
  logic       p_rsp_valid, p_rsp_ready, p_rsp_wr;
  logic [5:0] p_rsp_rdata, p_rsp_id;
  logic       p_dck, p_drl;
  logic [1:0] p_ds;
  logic [5:0] p_dra, p_dri, p_dro, p_did;

  assign p_dro = 6'h0C;
  assign p_did = 6'h21;

  nx_dly_reg_master #(.SETUP_CYC(3), .HOLD_CYC(2), .READ_LAT(4)) dut_p (
    .CK(CK), .RN(RN),
    .REQ_VALID(p_req_valid), .REQ_READY(p_req_ready), .REQ_WR(p_req_wr),
    .REQ_SEL(p_req_sel), .REQ_ADDR(p_req_addr), .REQ_WDATA(p_req_wdata),
    .RSP_VALID(p_rsp_valid), .RSP_READY(p_rsp_ready), .RSP_WR(p_rsp_wr),
    .RSP_RDATA(p_rsp_rdata), .RSP_ID(p_rsp_id),
    .DCK(p_dck), .DRL(p_drl), .DS(p_ds), .DRA(p_dra), .DRI(p_dri),
    .DRO(p_dro), .DID(p_did)
  );

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  logic       b_wr    [4];
  logic [5:0] b_addr  [4];
  logic       e_wr    [4];
  logic [5:0] e_rdata [4];
  logic [5:0] e_id    [4];

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   idx;
    int   nresp;
    int   npulse;
    int   last_dck;
    logic accepted;

    checks   = 0;
    failures = 0;

    b_wr[0] = 1'b1; b_addr[0] = 6'h01; e_wr[0] = 1'b1; e_rdata[0] = 6'h00; e_id[0] = 6'h00;
    b_wr[1] = 1'b0; b_addr[1] = 6'h10; e_wr[1] = 1'b0; e_rdata[1] = 6'h24; e_id[1] = 6'h11;
    b_wr[2] = 1'b0; b_addr[2] = 6'h2A; e_wr[2] = 1'b0; e_rdata[2] = 6'h1E; e_id[2] = 6'h11;
    b_wr[3] = 1'b1; b_addr[3] = 6'h3F; e_wr[3] = 1'b1; e_rdata[3] = 6'h00; e_id[3] = 6'h00;

    RN = 1'b0;
    req_valid = 1'b0; req_wr = 1'b0; req_sel = '0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0;
    p_req_valid = 1'b0; p_req_wr = 1'b0; p_req_sel = '0; p_req_addr = '0; p_req_wdata = '0;
    p_rsp_ready = 1'b0;

    step();
    step();
    checks++; if (req_ready !== 1'b0) fail("rst_req_ready", req_ready, 1'b0);
    checks++; if (rsp_valid !== 1'b0) fail("rst_rsp_valid", rsp_valid, 1'b0);
    checks++; if (dck !== 1'b0) fail("rst_dck", dck, 1'b0);
    checks++; if (drl !== 1'b0) fail("rst_drl", drl, 1'b0);
    checks++; if (ds !== 2'h0) fail("rst_ds", ds, 2'h0);
    checks++; if (dra !== 6'h00) fail("rst_dra", dra, 6'h00);
    checks++; if (dri !== 6'h00) fail("rst_dri", dri, 6'h00);
    checks++; if (rsp_rdata !== 6'h00) fail("rst_rsp_rdata", rsp_rdata, 6'h00);
    RN = 1'b1;
    step();
    checks++; if (req_ready !== 1'b1) fail("rel_req_ready", req_ready, 1'b1);

    req_valid = 1'b1; req_wr = 1'b1; req_sel = 2'd2; req_addr = 6'h15; req_wdata = 6'h2A;
    step();
    req_valid = 1'b0; req_wr = 1'b0; req_sel = '0; req_addr = '0; req_wdata = '0;
    checks++; if (req_ready !== 1'b0) fail("wr_e0_req_ready", req_ready, 1'b0);
    checks++; if (ds !== 2'h0) fail("wr_e0_ds", ds, 2'h0);
    step();
    checks++; if (ds !== 2'h2) fail("wr_e1_ds", ds, 2'h2);
    checks++; if (dra !== 6'h15) fail("wr_e1_dra", dra, 6'h15);
    checks++; if (dri !== 6'h2A) fail("wr_e1_dri", dri, 6'h2A);
    checks++; if (drl !== 1'b1) fail("wr_e1_drl", drl, 1'b1);
    checks++; if (dck !== 1'b0) fail("wr_e1_dck", dck, 1'b0);
    step();
    checks++; if (dck !== 1'b1) fail("wr_e2_dck", dck, 1'b1);
    checks++; if (ds !== 2'h2) fail("wr_e2_ds", ds, 2'h2);
    checks++; if (dra !== 6'h15) fail("wr_e2_dra", dra, 6'h15);
    checks++; if (dri !== 6'h2A) fail("wr_e2_dri", dri, 6'h2A);
    step();
    checks++; if (dck !== 1'b0) fail("wr_e3_dck", dck, 1'b0);
    checks++; if (drl !== 1'b1) fail("wr_e3_drl", drl, 1'b1);
    checks++; if (dra !== 6'h15) fail("wr_e3_dra", dra, 6'h15);
    checks++; if (rsp_valid !== 1'b0) fail("wr_e3_rsp_valid", rsp_valid, 1'b0);
    step();
    checks++; if (rsp_valid !== 1'b1) fail("wr_e4_rsp_valid", rsp_valid, 1'b1);
    checks++; if (rsp_wr !== 1'b1) fail("wr_e4_rsp_wr", rsp_wr, 1'b1);
    checks++; if (rsp_rdata !== 6'h00) fail("wr_e4_rsp_rdata", rsp_rdata, 6'h00);
    checks++; if (rsp_id !== 6'h00) fail("wr_e4_rsp_id", rsp_id, 6'h00);
    checks++; if (req_ready !== 1'b0) fail("wr_e4_req_ready", req_ready, 1'b0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) fail("wr_done_rsp_valid", rsp_valid, 1'b0);
    checks++; if (req_ready !== 1'b1) fail("wr_done_req_ready", req_ready, 1'b1);
    checks++; if (ds !== 2'h0) fail("wr_done_ds", ds, 2'h0);
    checks++; if (drl !== 1'b0) fail("wr_done_drl", drl, 1'b0);
    checks++; if (dra !== 6'h00) fail("wr_done_dra", dra, 6'h00);

    req_valid = 1'b1; req_wr = 1'b0; req_sel = 2'd1; req_addr = 6'h07; req_wdata = 6'h3F;
    step();
    req_valid = 1'b0;
    step();
    checks++; if (drl !== 1'b0) fail("rd_e1_drl", drl, 1'b0);
    checks++; if (dra !== 6'h07) fail("rd_e1_dra", dra, 6'h07);
    checks++; if (ds !== 2'h1) fail("rd_e1_ds", ds, 2'h1);
    step();
    checks++; if (dck !== 1'b1) fail("rd_e2_dck", dck, 1'b1);
    step();
    checks++; if (dck !== 1'b0) fail("rd_e3_dck", dck, 1'b0);
    step();
    checks++; if (rsp_valid !== 1'b0) fail("rd_e4_rsp_valid", rsp_valid, 1'b0);
    step();
    checks++; if (rsp_valid !== 1'b0) fail("rd_e5_rsp_valid", rsp_valid, 1'b0);
    step();
    checks++; if (rsp_valid !== 1'b1) fail("rd_e6_rsp_valid", rsp_valid, 1'b1);
    checks++; if (rsp_wr !== 1'b0) fail("rd_e6_rsp_wr", rsp_wr, 1'b0);
    checks++; if (rsp_rdata !== 6'h33) fail("rd_e6_rsp_rdata", rsp_rdata, 6'h33);
    checks++; if (rsp_id !== 6'h11) fail("rd_e6_rsp_id", rsp_id, 6'h11);

    for (int unsigned i = 0; i < 5; i++) begin
      req_valid = (i == 2);
      req_wr    = 1'b1;
      req_addr  = 6'h3C;
      step();
      checks++; if (rsp_valid !== 1'b1) fail("stall_rsp_valid", rsp_valid, 1'b1);
      checks++; if (rsp_rdata !== 6'h33) fail("stall_rsp_rdata", rsp_rdata, 6'h33);
      checks++; if (rsp_id !== 6'h11) fail("stall_rsp_id", rsp_id, 6'h11);
      checks++; if (req_ready !== 1'b0) fail("stall_req_ready", req_ready, 1'b0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) fail("stall_done_rsp_valid", rsp_valid, 1'b0);
    checks++; if (req_ready !== 1'b1) fail("stall_done_req_ready", req_ready, 1'b1);
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      checks++; if (dck !== 1'b0) fail("stall_no_access_dck", dck, 1'b0);
      checks++; if (dra !== 6'h00) fail("stall_no_access_dra", dra, 6'h00);
      checks++; if (drl !== 1'b0) fail("stall_no_access_drl", drl, 1'b0);
    end

    rsp_ready = 1'b1;
    idx = 0; nresp = 0; npulse = 0; last_dck = -1;
    req_valid = 1'b1; req_wr = b_wr[0]; req_sel = 2'd3; req_addr = b_addr[0]; req_wdata = 6'h05;
    for (int unsigned cyc = 0; cyc < 100; cyc++) begin
      accepted = req_valid && req_ready;
      step();
      if (accepted) begin
        idx++;
        if (idx < 4) begin
          req_wr   = b_wr[idx];
          req_addr = b_addr[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
      if (dck) begin
        if (last_dck >= 0) begin
          checks++; if ((int'(cyc) - last_dck) < 2) fail("b2b_dck_gap_ge2", int'(cyc) - last_dck, 2);
        end
        last_dck = int'(cyc);
        npulse++;
      end
      if (rsp_valid && nresp < 4) begin
        checks++; if (rsp_wr !== e_wr[nresp]) fail("b2b_rsp_wr", rsp_wr, e_wr[nresp]);
        checks++; if (rsp_rdata !== e_rdata[nresp]) fail("b2b_rsp_rdata", rsp_rdata, e_rdata[nresp]);
        checks++; if (rsp_id !== e_id[nresp]) fail("b2b_rsp_id", rsp_id, e_id[nresp]);
        nresp++;
      end
      if (nresp == 4) break;
    end
    step();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    checks++; if (nresp != 4) fail("b2b_responses", nresp, 4);
    checks++; if (npulse != 4) fail("b2b_dck_pulses", npulse, 4);

    p_req_valid = 1'b1; p_req_wr = 1'b0; p_req_sel = 2'd3; p_req_addr = 6'h09; p_req_wdata = 6'h05;
    step();
    p_req_valid = 1'b0;
    for (int unsigned n = 1; n <= 11; n++) begin
      step();
      checks++; if (p_dck !== (n == 4)) fail("par_dck", p_dck, (n == 4));
      checks++; if (p_rsp_valid !== (n >= 11)) fail("par_rsp_valid", p_rsp_valid, (n >= 11));
    end
    checks++; if (p_rsp_rdata !== 6'h0C) fail("par_rsp_rdata", p_rsp_rdata, 6'h0C);
    checks++; if (p_rsp_id !== 6'h21) fail("par_rsp_id", p_rsp_id, 6'h21);
    checks++; if (p_rsp_wr !== 1'b0) fail("par_rsp_wr", p_rsp_wr, 1'b0);
    checks++; if (p_drl !== 1'b0) fail("par_drl", p_drl, 1'b0);
    checks++; if (p_ds !== 2'h3) fail("par_ds", p_ds, 2'h3);
    checks++; if (p_dra !== 6'h09) fail("par_dra", p_dra, 6'h09);
    checks++; if (p_dri !== 6'h05) fail("par_dri", p_dri, 6'h05);
    p_rsp_ready = 1'b1;
    step();
    p_rsp_ready = 1'b0;
    checks++; if (p_req_ready !== 1'b1) fail("par_done_req_ready", p_req_ready, 1'b1);

    req_valid = 1'b1; req_wr = 1'b1; req_sel = 2'd1; req_addr = 6'h22; req_wdata = 6'h19;
    step();
    req_valid = 1'b0;
    step();
    step();
    checks++; if (dck !== 1'b1) fail("rstmid_dck_before", dck, 1'b1);
    #2 RN = 1'b0;
    #1;
    checks++; if (dck !== 1'b0) fail("rstmid_dck", dck, 1'b0);
    checks++; if (ds !== 2'h0) fail("rstmid_ds", ds, 2'h0);
    checks++; if (dra !== 6'h00) fail("rstmid_dra", dra, 6'h00);
    checks++; if (dri !== 6'h00) fail("rstmid_dri", dri, 6'h00);
    checks++; if (drl !== 1'b0) fail("rstmid_drl", drl, 1'b0);
    checks++; if (req_ready !== 1'b0) fail("rstmid_req_ready", req_ready, 1'b0);
    step();
    RN = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      step();
      checks++; if (rsp_valid !== 1'b0) fail("rstmid_no_rsp", rsp_valid, 1'b0);
      checks++; if (dck !== 1'b0) fail("rstmid_no_dck", dck, 1'b0);
    end
    checks++; if (req_ready !== 1'b1) fail("rstmid_req_ready_after", req_ready, 1'b1);

    req_valid = 1'b1; req_wr = 1'b0; req_sel = 2'd0; req_addr = 6'h01; req_wdata = 6'h00;
    step();
    req_valid = 1'b0;
    for (int unsigned i = 1; i <= 6; i++) step();
    checks++; if (rsp_valid !== 1'b1) fail("post_rst_rsp_valid", rsp_valid, 1'b1);
    checks++; if (rsp_rdata !== 6'h35) fail("post_rst_rsp_rdata", rsp_rdata, 6'h35);
    checks++; if (rsp_id !== 6'h11) fail("post_rst_rsp_id", rsp_id, 6'h11);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) fail("post_rst_done", rsp_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
